// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin sharing of a single-cycle memory's read/write
// ports among NUM_REQ requesters.  Optional stats: MEM_PORT_ARB_STATS_EN.
// Revision: 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_SIZE   = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_rdata,
   output logic                          resp_err,
   output logic                          mem_read_enable,
   output logic [ADDR_WIDTH-1:0]         mem_read_addr,
   input  logic [DATA_WIDTH-1:0]         mem_read_data,
   output logic                          mem_write_enable,
   output logic [ADDR_WIDTH-1:0]         mem_write_addr,
   output logic [DATA_WIDTH-1:0]         mem_write_data
`ifdef MEM_PORT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         grant_count,
   output logic [15:0]                   err_count
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [IDX_W-1:0]        rr_ptr, owner, winner;
   logic [IDX_W:0]          scan_idx;
   logic                    found, handshake, in_range, issue_rd, issue_wr;
   logic                    lat_we;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;

   // Scan from rr_ptr with wrap; the extra index bit absorbs rr_ptr + k overflow
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan_idx >= (IDX_W+1)'(NUM_REQ))
            scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
         if (!found && req_valid[scan_idx[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = scan_idx[IDX_W-1:0];
         end
      end
   end

   assign handshake = (state == IDLE) && found && !reset;
   assign in_range  = lat_addr < ADDR_WIDTH'(MEM_SIZE);
   // Reset gates the enables so an access caught in ISSUE never commits
   assign issue_rd  = (state == ISSUE) && !reset && !lat_we && in_range;
   assign issue_wr  = (state == ISSUE) && !reset &&  lat_we && in_range;

   assign mem_read_enable  = issue_rd;
   assign mem_read_addr    = issue_rd ? lat_addr  : '0;
   assign mem_write_enable = issue_wr;
   assign mem_write_addr   = issue_wr ? lat_addr  : '0;
   assign mem_write_data   = issue_wr ? lat_wdata : '0;

   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      if (handshake)
         req_ready[winner] = 1'b1;
      if (state == RESP && !reset)
         resp_valid[owner] = 1'b1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (handshake) begin
            lat_we    <= req_we[winner];
            lat_addr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            owner     <= winner;
            rr_ptr    <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         end
         if (state == ISSUE) begin
            resp_rdata <= issue_rd ? mem_read_data : '0;
            resp_err   <= !in_range;
         end
      end
   end

`ifdef MEM_PORT_ARB_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
      always_ff @(posedge clk) begin
         if (reset)
            grant_count[g*16 +: 16] <= '0;
         else if (handshake && winner == IDX_W'(g) && grant_count[g*16 +: 16] != 16'hFFFF)
            grant_count[g*16 +: 16] <= grant_count[g*16 +: 16] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else if (state == ISSUE && !in_range && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif

endmodule

`default_nettype wire
